rsa_decrypt_unit: RTL

//   Computes P = C^D mod M, the decryption counterpart of the RSA encrypt datapath.

---
 rtl/rsa_pkg.sv | 27 ++
 rtl/mmm_serial_unit.sv | 76 +++++++
 rtl/rsa_decrypt_unit.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/rsa_pkg.sv
// Shared types and sizing helpers for the RSA decrypt datapath.
// The exponent-skip option is selected in the top with RSA_DEC_EXP_SKIP_EN.
package rsa_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT_X,
        ST_INIT_A,
        ST_SQR,
        ST_MUL,
        ST_CONV,
        ST_REDUCE,
        ST_DONE
    } rsa_dec_state_t;

    // Load cycle plus done/issue cycle wrapped around the serial iterations.
    localparam int unsigned MMM_OVERHEAD_CYCLES = 2;

    function automatic int unsigned mmm_width(input int unsigned width);
        return width + 2;
    endfunction

    function automatic int unsigned mmm_cycles(input int unsigned width);
        return mmm_width(width) + MMM_OVERHEAD_CYCLES;
    endfunction

endpackage

// File: rtl/mmm_serial_unit.sv
// Bit-serial Montgomery multiplier: R = A*B*2^-(WIDTH+2) mod M (result < 2M).
// One iteration per cycle after the load cycle; done pulses once for a single cycle.
module mmm_serial_unit
    import rsa_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic                          clk,
    input  logic                          rstb,
    input  logic                          ena,
    input  logic                          clear,
    input  logic                          start,
    input  logic [mmm_width(WIDTH)-1:0]   A,
    input  logic [mmm_width(WIDTH)-1:0]   B,
    input  logic [WIDTH-1:0]              M,
    output logic [mmm_width(WIDTH)-1:0]   R,
    output logic                          done
);

    localparam int unsigned MW    = mmm_width(WIDTH);
    localparam int unsigned AW    = MW + 1;
    localparam int unsigned ITERS = mmm_cycles(WIDTH) - MMM_OVERHEAD_CYCLES;
    localparam int unsigned CW    = $clog2(ITERS + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(ITERS - 1);

    logic [MW-1:0]    r_a;
    logic [MW-1:0]    r_b;
    logic [MW-1:0]    r_r;
    logic [WIDTH-1:0] r_m;
    logic [CW-1:0]    r_cnt;
    logic             r_run;
    logic             r_done;

    logic [AW-1:0]    w_sum;
    logic [AW-1:0]    w_acc;

    // One iteration: add a[i]*b, make even by adding M, then halve.
    always_comb begin
        w_sum = AW'(r_r) + (r_a[0] ? AW'(r_b) : AW'(0));
        w_acc = w_sum + (w_sum[0] ? AW'(r_m) : AW'(0));
    end

    always_ff @(posedge clk) begin
        if (!rstb || (ena && !clear)) begin
            r_a    <= '0;
            r_b    <= '0;
            r_r    <= '0;
            r_m    <= '0;
            r_cnt  <= '0;
            r_run  <= 1'b0;
            r_done <= 1'b0;
        end else if (ena) begin
            r_done <= 1'b0;
            if (start) begin
                r_a   <= A;
                r_b   <= B;
                r_m   <= M;
                r_r   <= '0;
                r_cnt <= '0;
                r_run <= 1'b1;
            end else if (r_run) begin
                r_r   <= w_acc[AW-1:1];
                r_a   <= r_a >> 1;
                r_cnt <= r_cnt + CW'(1);
                if (r_cnt == LAST_CNT) begin
                    r_run  <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign R    = r_r;
    assign done = r_done;

endmodule

// File: rtl/rsa_decrypt_unit.sv
// RSA decrypt P = C^D mod M via left-to-right square-and-multiply on one Montgomery multiplier.
// Define RSA_DEC_EXP_SKIP_EN to start the exponent loop at the most significant set bit of D.
module rsa_decrypt_unit
    import rsa_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             ena,
    input  logic             clear,
    input  logic             start,
    input  logic [WIDTH-1:0] C,
    input  logic [WIDTH-1:0] D,
    input  logic [WIDTH-1:0] M,
    input  logic [WIDTH-1:0] Const,
    output logic [WIDTH-1:0] P,
    output logic             eoc,
    output logic             busy
);

    localparam int unsigned MW = mmm_width(WIDTH);
    localparam int unsigned IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    rsa_dec_state_t   r_state, w_state;
    logic             r_issue, w_issue;
    logic [IW-1:0]    r_idx, w_idx;
    logic [MW-1:0]    r_x, w_x;
    logic [MW-1:0]    r_a, w_a;
    logic [WIDTH-1:0] r_c, w_c;
    logic [WIDTH-1:0] r_d, w_d;
    logic [WIDTH-1:0] r_m, w_m;
    logic [WIDTH-1:0] r_const, w_const;
    logic [WIDTH-1:0] r_p, w_p;
    logic             r_eoc, w_eoc;
    logic             r_busy, w_busy;

    logic [MW-1:0]    w_mmm_a;
    logic [MW-1:0]    w_mmm_b;
    logic [MW-1:0]    w_mmm_r;
    logic             w_mmm_done;

    mmm_serial_unit #(.WIDTH(WIDTH)) u_mmm (
        .clk   (clk),
        .rstb  (rstb),
        .ena   (ena),
        .clear (clear),
        .start (r_issue),
        .A     (w_mmm_a),
        .B     (w_mmm_b),
        .M     (r_m),
        .R     (w_mmm_r),
        .done  (w_mmm_done)
    );

    // Multiplier operand selection per step.
    always_comb begin
        w_mmm_a = r_a;
        w_mmm_b = MW'(1);
        case (r_state)
            ST_INIT_X: begin
                w_mmm_a = MW'(r_c);
                w_mmm_b = MW'(r_const);
            end
            ST_INIT_A: w_mmm_a = MW'(r_const);
            ST_SQR:    w_mmm_b = r_a;
            ST_MUL:    w_mmm_b = r_x;
            default:   ;
        endcase
    end

`ifdef RSA_DEC_EXP_SKIP_EN
    logic [IW-1:0] w_msb;

    always_comb begin
        w_msb = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            if (r_d[i]) w_msb = IW'(i);
        end
    end
`endif

    always_comb begin
        w_state = r_state;
        w_issue = 1'b0;
        w_idx   = r_idx;
        w_x     = r_x;
        w_a     = r_a;
        w_c     = r_c;
        w_d     = r_d;
        w_m     = r_m;
        w_const = r_const;
        w_p     = r_p;
        w_eoc   = r_eoc;
        w_busy  = r_busy;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    w_c     = C;
                    w_d     = D;
                    w_m     = M;
                    w_const = Const;
                    w_state = ST_INIT_X;
                    w_issue = 1'b1;
                    w_busy  = 1'b1;
                    w_eoc   = 1'b0;
                end
            end
            ST_INIT_X: begin
                if (w_mmm_done) begin
                    w_x     = w_mmm_r;
                    w_state = ST_INIT_A;
                    w_issue = 1'b1;
                end
            end
            ST_INIT_A: begin
                if (w_mmm_done) begin
                    w_a     = w_mmm_r;
                    w_issue = 1'b1;
`ifdef RSA_DEC_EXP_SKIP_EN
                    if (r_d == '0) begin
                        w_state = ST_CONV;
                    end else begin
                        w_idx   = w_msb;
                        w_state = ST_SQR;
                    end
`else
                    w_idx   = IW'(WIDTH - 1);
                    w_state = ST_SQR;
`endif
                end
            end
            ST_SQR: begin
                if (w_mmm_done) begin
                    w_a     = w_mmm_r;
                    w_issue = 1'b1;
                    if (r_d[r_idx]) begin
                        w_state = ST_MUL;
                    end else if (r_idx == '0) begin
                        w_state = ST_CONV;
                    end else begin
                        w_idx = r_idx - IW'(1);
                    end
                end
            end
            ST_MUL: begin
                if (w_mmm_done) begin
                    w_a     = w_mmm_r;
                    w_issue = 1'b1;
                    if (r_idx == '0) begin
                        w_state = ST_CONV;
                    end else begin
                        w_idx   = r_idx - IW'(1);
                        w_state = ST_SQR;
                    end
                end
            end
            ST_CONV: begin
                if (w_mmm_done) begin
                    w_a     = w_mmm_r;
                    w_state = ST_REDUCE;
                end
            end
            ST_REDUCE: begin
                // Out of the Montgomery domain the value is below 2M; one subtraction suffices.
                w_p     = (r_a >= MW'(r_m)) ? WIDTH'(r_a - MW'(r_m)) : WIDTH'(r_a);
                w_eoc   = 1'b1;
                w_busy  = 1'b0;
                w_state = ST_DONE;
            end
            default: w_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstb || (ena && !clear)) begin
            r_state <= ST_IDLE;
            r_issue <= 1'b0;
            r_idx   <= '0;
            r_x     <= '0;
            r_a     <= '0;
            r_c     <= '0;
            r_d     <= '0;
            r_m     <= '0;
            r_const <= '0;
            r_p     <= '0;
            r_eoc   <= 1'b0;
            r_busy  <= 1'b0;
        end else if (ena) begin
            r_state <= w_state;
            r_issue <= w_issue;
            r_idx   <= w_idx;
            r_x     <= w_x;
            r_a     <= w_a;
            r_c     <= w_c;
            r_d     <= w_d;
            r_m     <= w_m;
            r_const <= w_const;
            r_p     <= w_p;
            r_eoc   <= w_eoc;
            r_busy  <= w_busy;
        end
    end

    assign P    = r_p;
    assign eoc  = r_eoc;
    assign busy = r_busy;

endmodule
